// File: rtl/bank_write_packer_if.sv
// Stream-in / bank-write interface for bank_write_packer.
// The master side feeds 32-bit words and control; the slave side (the packer)
// returns ready, the bank write port and status.
interface bank_write_packer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned ADDR_W = 7
) ();

    logic                vsi_start;
    logic [ADDR_W-1:0]   vsi_baseAddr;
    logic [DATA_W-1:0]   vsi_inData;
    logic                vsi_inValid;
    logic                vsi_inLast;
    logic                vsi_inReady;
    logic [LINE_W-1:0]   vsi_inputData;
    logic [ADDR_W-1:0]   vsi_inputAddr;
    logic                vsi_inputChipSelect;
    logic                vsi_full;
    logic                vsi_frameDone;
    logic [ADDR_W:0]     vsi_lineCount;

    // Producer side: drives the stream and control, observes the bank port.
    modport master (
        output vsi_start,
        output vsi_baseAddr,
        output vsi_inData,
        output vsi_inValid,
        output vsi_inLast,
        input  vsi_inReady,
        input  vsi_inputData,
        input  vsi_inputAddr,
        input  vsi_inputChipSelect,
        input  vsi_full,
        input  vsi_frameDone,
        input  vsi_lineCount
    );

    // Packer side.
    modport slave (
        input  vsi_start,
        input  vsi_baseAddr,
        input  vsi_inData,
        input  vsi_inValid,
        input  vsi_inLast,
        output vsi_inReady,
        output vsi_inputData,
        output vsi_inputAddr,
        output vsi_inputChipSelect,
        output vsi_full,
        output vsi_frameDone,
        output vsi_lineCount
    );

endinterface

// File: rtl/bank_write_packer.sv
// bank_write_packer: packs a 32-bit valid/ready word stream into 128-bit
// lines and issues single-cycle writes to a DEPTH-entry bank at an
// auto-incrementing address. Frames may end on a partial (zero-padded) line.
// Optional build macro BANK_PACK_WRAP_EN: the write pointer wraps to 0 after
// DEPTH-1 instead of stalling in FULL, and the line counter wraps.
module bank_write_packer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                 vsi_clk,
    input  logic                 vsi_reset,
    bank_write_packer_if.slave   bus
);

    localparam int unsigned LANES  = LINE_W / DATA_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

    // FSM encoding
    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    logic [LANE_W-1:0]   r_lane;
    logic [LINE_W-1:0]   r_pack;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]    r_line_count;

    logic [LINE_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_cs;
    logic                r_frame_done;
    logic                r_in_ready;
    logic                r_full;

    logic                w_accept;
    logic                w_line_done;
    logic                w_at_last_addr;
    logic [LINE_W-1:0]   w_line_data;
    logic [ADDR_W-1:0]   w_ptr_inc;
    logic [CNT_W-1:0]    w_count_inc;

    // Handshake: start takes priority and discards a word offered alongside it.
    assign w_accept       = bus.vsi_inValid & r_in_ready & ~bus.vsi_start;
    assign w_line_done    = w_accept & ((r_lane == LAST_LANE) | bus.vsi_inLast);
    assign w_at_last_addr = (r_wr_ptr == LAST_ADDR);

    // Packing buffer with the current word merged into its lane.
    always_comb begin
        w_line_data = r_pack;
        for (int i = 0; i < int'(LANES); i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_line_data[i*DATA_W +: DATA_W] = bus.vsi_inData;
            end
        end
    end

    // Address and line-count advance rules.
    always_comb begin
        w_ptr_inc = w_at_last_addr ? '0 : r_wr_ptr + ADDR_W'(1);
`ifdef BANK_PACK_WRAP_EN
        w_count_inc = r_line_count + CNT_W'(1);
`else
        w_count_inc = (r_line_count >= CNT_MAX) ? CNT_MAX : r_line_count + CNT_W'(1);
`endif
    end

    // FSM state register.
    always_ff @(posedge vsi_clk) begin
        if (vsi_reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: FULL after writing the last bank entry; start always returns to FILL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: begin
`ifndef BANK_PACK_WRAP_EN
                if (w_line_done && w_at_last_addr) begin
                    w_state_next = S_FULL;
                end
`endif
            end
            S_FULL: begin
                w_state_next = S_FULL;
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
        if (bus.vsi_start) begin
            w_state_next = S_FILL;
        end
    end

    // Status registers: ready is low in FULL and for one cycle after start.
    always_ff @(posedge vsi_clk) begin
        if (vsi_reset) begin
            r_in_ready <= 1'b1;
            r_full     <= 1'b0;
        end else begin
            r_in_ready <= ~bus.vsi_start & (w_state_next == S_FILL);
            r_full     <= (w_state_next == S_FULL);
        end
    end

    // Packing datapath and bank write port; output line holds while the next fills.
    always_ff @(posedge vsi_clk) begin
        if (vsi_reset) begin
            r_lane       <= '0;
            r_pack       <= '0;
            r_wr_ptr     <= '0;
            r_line_count <= '0;
            r_out_data   <= '0;
            r_out_addr   <= '0;
            r_out_cs     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_cs     <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.vsi_start) begin
                r_wr_ptr     <= bus.vsi_baseAddr;
                r_lane       <= '0;
                r_pack       <= '0;
                r_line_count <= '0;
            end else if (w_line_done) begin
                r_out_data   <= w_line_data;
                r_out_addr   <= r_wr_ptr;
                r_out_cs     <= 1'b1;
                r_frame_done <= bus.vsi_inLast;
                r_wr_ptr     <= w_ptr_inc;
                r_line_count <= w_count_inc;
                r_lane       <= '0;
                r_pack       <= '0;
            end else if (w_accept) begin
                r_pack <= w_line_data;
                r_lane <= r_lane + LANE_W'(1);
            end
        end
    end

    // Output drive.
    assign bus.vsi_inReady         = r_in_ready;
    assign bus.vsi_inputData       = r_out_data;
    assign bus.vsi_inputAddr       = r_out_addr;
    assign bus.vsi_inputChipSelect = r_out_cs;
    assign bus.vsi_frameDone       = r_frame_done;
    assign bus.vsi_lineCount       = r_line_count;
    assign bus.vsi_full            = r_full;

endmodule
